fetch_prefetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_prefetch.sv | 127 ++++++++++++
 tb/tb_fetch_prefetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the prefetching fetch stage.
//   - redirect-select encodings driven on contMux4
//   - fetch FSM state type (also exported on the debug state port)
//   - sequential PC increment
package fetch_pkg;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;
  localparam logic [1:0] SEL_JALR   = 2'b11;

  // S_IDLE: no request outstanding
  // S_WAIT: request outstanding, its response will be queued
  // S_DROP: request outstanding, its response will be discarded
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetchStateT;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, holding {pc, instruction} pairs.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   push, pushData: write one entry (ignored when full)
//   pop           : remove head entry (ignored when empty)
//   flush         : empty the queue; overrides push and pop in the same cycle
//   full, empty   : occupancy flags
//   headData      : head entry, forced to 0 while empty so it is never X
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clock) begin
    if (doPush && !flush && !reset) store[wrPtr] <= pushData;
  end

  assign headData = empty ? '0 : store[rdPtr];

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: fetch stage with PC register, redirect mux, handshaked
// instruction-memory requests and a small prefetch queue toward decode.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   contMux4            : redirect select (none / branch / JAL / JALR)
//   intExtend/JAL/JALR  : redirect targets (JALR bit 0 cleared)
//   imem_req_*          : fetch request channel (valid/ready, addr)
//   imem_rsp_*          : in-order response, at least 1 cycle after acceptance
//   out_valid/out_ready : queue head handshake toward decode
//   outINPUT, outPC     : head instruction and its PC
//   dbgState            : current fetch FSM state
//
// Handshakes: a transfer happens in a cycle where valid && ready are both
// high at the rising edge. The fetch side may drop imem_req_valid before it
// is accepted (on a redirect); no payload is otherwise changed while waiting.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      contMux4,
  input  logic [XLEN-1:0] intExtend,
  input  logic [XLEN-1:0] intJAL,
  input  logic [XLEN-1:0] intJALR,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] outINPUT,
  output logic [XLEN-1:0] outPC,
  output fetchStateT      dbgState
);

  fetchStateT        state;
  fetchStateT        stateNext;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   reqPc;
  logic [XLEN-1:0]   target;
  logic              redirect;
  logic              accept;
  logic              push;
  logic              full;
  logic              empty;
  logic [2*XLEN-1:0] headData;

  assign redirect = (contMux4 != SEL_NONE);

  always_comb begin
    target = pc;
    case (contMux4)
      SEL_BRANCH: target = intExtend;
      SEL_JAL:    target = intJAL;
      SEL_JALR:   target = {intJALR[XLEN-1:1], 1'b0};
      default:    target = pc;
    endcase
  end

  // Requests only start from IDLE, so at most one is ever outstanding. A
  // redirect turns an outstanding request into one whose response is dropped.
  always_comb begin
    stateNext      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      S_IDLE: begin
        imem_req_valid = !reset && !full && !redirect;
        if (imem_req_valid && imem_req_ready) stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          push      = !redirect;
          stateNext = S_IDLE;
        end else if (redirect) begin
          stateNext = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  assign accept = imem_req_valid && imem_req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      reqPc <= '0;
    end else begin
      state <= stateNext;
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + XLEN'(PC_INCR);
      if (accept) reqPc <= pc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData ({reqPc, imem_rsp_data}),
    .pop      (out_valid && out_ready),
    .flush    (redirect),
    .full     (full),
    .empty    (empty),
    .headData (headData)
  );

  assign imem_req_addr = pc;
  assign out_valid     = !empty;
  assign outPC         = headData[2*XLEN-1:XLEN];
  assign outINPUT      = headData[XLEN-1:0];
  assign dbgState      = state;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed scenarios followed by a random phase.
// A behavioural memory drives the imem interface; a reference model (queue of
// {pc, data} pairs plus "request outstanding"/"discard" flags) predicts every
// output each cycle.
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clock;
  logic        reset;
  logic [1:0]  contMux4;
  logic [31:0] intExtend, intJAL, intJALR;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid, out_ready;
  logic [31:0] outINPUT, outPC;
  fetchStateT  dbgState;

  fetch_prefetch #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock), .reset(reset), .contMux4(contMux4),
    .intExtend(intExtend), .intJAL(intJAL), .intJALR(intJALR),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .outINPUT(outINPUT), .outPC(outPC),
    .dbgState(dbgState)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  // memory model
  bit          memBusy;
  int          memCnt;
  logic [31:0] memData;
  int          memLat;
  bit          readyEn;
  bit          randData;

  // reference model
  logic [31:0] mPc, mReqPc;
  bit          mBusy, mDrop;
  logic [63:0] expQ[$];

  // values sampled at the falling edge of the last cycle
  bit          sReqValid, sAcc, sPop, sOutValid;
  logic [31:0] sReqAddr, sOutPC, sOutData;
  logic [31:0] reqLog[$];
  logic [63:0] outLog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory outputs, check at negedge, update at posedge.
  task automatic cycle();
    logic [31:0] tgt;
    bit          redir, expReq, expOut, acc, pop;
    imem_rsp_valid = memBusy && (memCnt == 0);
    imem_rsp_data  = (memBusy && (memCnt == 0)) ? memData : 32'h0;
    imem_req_ready = !memBusy && readyEn;
    @(negedge clock);
    redir  = (contMux4 != 2'b00);
    expReq = !reset && !mBusy && (expQ.size() < DEPTH) && !redir;
    expOut = (expQ.size() != 0);
    sReqValid = imem_req_valid;
    sReqAddr  = imem_req_addr;
    sOutValid = out_valid;
    sOutPC    = outPC;
    sOutData  = outINPUT;
    check("req_valid", 64'(sReqValid), 64'(expReq));
    if (expReq) check("req_addr", 64'(sReqAddr), 64'(mPc));
    check("out_valid", 64'(sOutValid), 64'(expOut));
    if (expOut) begin
      check("out_pc", 64'(sOutPC), 64'(expQ[0][63:32]));
      check("out_data", 64'(sOutData), 64'(expQ[0][31:0]));
    end
    sAcc = sReqValid && imem_req_ready;
    sPop = sOutValid && out_ready;
    if (sAcc) reqLog.push_back(sReqAddr);
    if (sPop) outLog.push_back({sOutPC, sOutData});
    @(posedge clock);
    acc = expReq && imem_req_ready;
    pop = expOut && out_ready;
    if (reset) begin
      expQ.delete();
      mPc   = RESET_PC;
      mBusy = 0;
      mDrop = 0;
    end else begin
      case (contMux4)
        2'b01:   tgt = intExtend;
        2'b10:   tgt = intJAL;
        2'b11:   tgt = intJALR & ~32'h1;
        default: tgt = mPc;
      endcase
      if (redir) begin
        expQ.delete();
        mPc = tgt;
        if (mBusy) begin
          if (imem_rsp_valid) begin
            mBusy = 0;
            mDrop = 0;
          end else begin
            mDrop = 1;
          end
        end
      end else begin
        if (pop) void'(expQ.pop_front());
        if (mBusy && imem_rsp_valid) begin
          if (!mDrop) expQ.push_back({mReqPc, imem_rsp_data});
          mBusy = 0;
          mDrop = 0;
        end
        if (acc) begin
          mReqPc = mPc;
          mPc    = mPc + 32'd4;
          mBusy  = 1;
        end
      end
    end
    // memory follows what the DUT actually did on the bus
    if (memBusy) begin
      if (memCnt == 0) memBusy = 0;
      else memCnt--;
    end
    if (sAcc) begin
      memBusy = 1;
      memCnt  = memLat - 1;
      memData = randData ? $urandom : sReqAddr + 32'h100;
    end
    #1;
  endtask

  task automatic waitAcc(input string tag);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      found = sAcc;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic waitPop(input string tag);
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      found = sPop;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  initial begin
    int n;
    int m;
    bit found;
    checks = 0; errors = 0;
    reset = 1; contMux4 = 2'b00;
    intExtend = 0; intJAL = 0; intJALR = 0;
    out_ready = 1; readyEn = 1; memLat = 1; randData = 0;
    memBusy = 0; memCnt = 0; memData = 0;
    mPc = RESET_PC; mReqPc = 0; mBusy = 0; mDrop = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; imem_req_ready = 0;

    // reset: 2 cycles; outputs only defined after the first edge
    @(posedge clock); #1;
    cycle();
    check("rst_out_pc", 64'(sOutPC), 64'd0);
    check("rst_out_data", 64'(sOutData), 64'd0);
    check("rst_state", 64'(dbgState), 64'(S_IDLE));
    reset = 0;

    // streaming with 1-cycle memory
    reqLog.delete(); outLog.delete();
    repeat (8) cycle();
    check("s1_nreq", 64'(reqLog.size() >= 3), 64'd1);
    check("s1_nout", 64'(outLog.size()), 64'd3);
    if (reqLog.size() >= 3) begin
      check("s1_req0", 64'(reqLog[0]), 64'h0);
      check("s1_req1", 64'(reqLog[1]), 64'h4);
      check("s1_req2", 64'(reqLog[2]), 64'h8);
    end
    if (outLog.size() >= 3) begin
      check("s1_out0", outLog[0], 64'h0000_0000_0000_0100);
      check("s1_out1", outLog[1], 64'h0000_0004_0000_0104);
      check("s1_out2", outLog[2], 64'h0000_0008_0000_0108);
    end

    // back-pressure: fill the queue from a fresh target
    out_ready = 0; contMux4 = 2'b01; intExtend = 32'h1000;
    cycle();
    contMux4 = 2'b00;
    n = reqLog.size();
    repeat (16) cycle();
    check("bp_nreq", 64'(reqLog.size() - n), 64'd4);
    check("bp_req_stalled", 64'(sReqValid), 64'd0);
    out_ready = 1;
    m = outLog.size();
    cycle();
    check("bp_npop", 64'(outLog.size() - m), 64'd1);
    if (outLog.size() > m) check("bp_pop_pc", 64'(outLog[m][63:32]), 64'h1000);
    out_ready = 0;
    cycle();
    check("bp_rereq_valid", 64'(sReqValid), 64'd1);
    check("bp_rereq_addr", 64'(sReqAddr), 64'h1010);

    // redirect during WAIT, latency 3
    out_ready = 1; memLat = 3;
    waitAcc("jal_acc0");
    contMux4 = 2'b10; intJAL = 32'h40;
    cycle();
    contMux4 = 2'b00;
    m = outLog.size();
    waitAcc("jal_acc1");
    check("jal_req_addr", 64'(sReqAddr), 64'h40);
    waitPop("jal_pop");
    check("jal_first_out", 64'(outLog.size() - m), 64'd1);
    check("jal_out", outLog[outLog.size()-1], 64'h0000_0040_0000_0140);

    // JALR target with bit 0 set, redirect coinciding with the response
    memLat = 2;
    waitAcc("jalr_acc0");
    cycle();
    contMux4 = 2'b11; intJALR = 32'h81;
    cycle();
    contMux4 = 2'b00;
    cycle();
    check("jalr_empty", 64'(sOutValid), 64'd0);
    check("jalr_req_valid", 64'(sReqValid), 64'd1);
    check("jalr_req_addr", 64'(sReqAddr), 64'h80);

    // flush with simultaneous pop, then reset while WAIT
    memLat = 1; out_ready = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = (expQ.size() == 3);
    end
    check("fl_fill", 64'(found), 64'd1);
    out_ready = 1; contMux4 = 2'b01; intExtend = 32'h200; memLat = 3;
    cycle();
    contMux4 = 2'b00;
    cycle();
    check("fl_empty", 64'(sOutValid), 64'd0);
    found = sAcc;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = sAcc;
    end
    check("fl_acc", 64'(found), 64'd1);
    check("fl_req_addr", 64'(sReqAddr), 64'h200);
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    check("mrst_req_valid", 64'(sReqValid), 64'd1);
    check("mrst_req_addr", 64'(sReqAddr), 64'(RESET_PC));
    m = outLog.size();
    waitPop("mrst_pop");
    check("mrst_first_out", 64'(outLog.size() - m), 64'd1);
    check("mrst_out", outLog[outLog.size()-1], {RESET_PC, RESET_PC + 32'h100});

    // random phase
    randData = 1;
    for (int i = 0; i < 400; i++) begin
      contMux4  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      intExtend = $urandom;
      intJAL    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : $urandom;
      intJALR   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      readyEn   = ($urandom_range(0, 3) != 0);
      memLat    = $urandom_range(1, 4);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 0; contMux4 = 2'b00;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
